// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: FSM state encoding and the queued command record.
package i2c_pkg;

  localparam int I2C_DATA_BYTES = 4;
  localparam int I2C_BYTE_WIDTH = $clog2(I2C_DATA_BYTES);
  localparam int I2C_DATA_WIDTH = I2C_DATA_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RESPOND
  } seq_state_t;

  typedef struct packed {
    logic                      rw;
    logic [6:0]                dev_addr;
    logic [I2C_DATA_WIDTH-1:0] reg_addr;
    logic [I2C_BYTE_WIDTH-1:0] addr_bytes;
    logic [I2C_BYTE_WIDTH-1:0] data_bytes;
    logic [I2C_DATA_WIDTH-1:0] wdata;
  } i2c_cmd_t;

  localparam int I2C_CMD_WIDTH = $bits(i2c_cmd_t);

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally so it can be popped into
// the issue registers on the same edge.
module i2c_cmd_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = I2C_CMD_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (level_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];
  assign level   = level_reg;

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host register accesses and issues them one at a time to the I2C byte controller.
// Optional I2C_TIMEOUT_EN adds a completion watchdog of TIMEOUT_CYCLES clocks.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int DATA_BYTES     = I2C_DATA_BYTES,
  parameter int BYTE_WIDTH     = $clog2(DATA_BYTES),
  parameter int DATA_WIDTH     = DATA_BYTES * 8,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rw,
  input  logic [6:0]                  cmd_dev_addr,
  input  logic [DATA_WIDTH-1:0]       cmd_reg_addr,
  input  logic [BYTE_WIDTH-1:0]       cmd_addr_bytes,
  input  logic [BYTE_WIDTH-1:0]       cmd_data_bytes,
  input  logic [DATA_WIDTH-1:0]       cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic                        rsp_error,
  output logic                        access_request,
  output logic [7:0]                  dev_id,
  output logic [DATA_WIDTH-1:0]       address,
  output logic [BYTE_WIDTH-1:0]       address_byte,
  output logic [BYTE_WIDTH-1:0]       data_byte,
  output logic [DATA_WIDTH-1:0]       write_data,
  input  logic [DATA_WIDTH-1:0]       read_data,
  input  logic                        access_complete,
  input  logic                        invalid_access,
  input  logic                        busy,
  output logic [$clog2(CMD_DEPTH):0]  cmd_level
);

  seq_state_t                 state_reg, state_next;
  i2c_cmd_t                   cmd_in, cmd_head;
  logic [I2C_CMD_WIDTH-1:0]   head_bits;
  logic                       fifo_full, fifo_empty;
  logic                       issue_load, capture, capture_err, timeout_hit;
  logic                       rw_reg;
  logic [7:0]                 dev_id_reg;
  logic [DATA_WIDTH-1:0]      address_reg, write_data_reg, rsp_rdata_reg;
  logic [BYTE_WIDTH-1:0]      address_byte_reg, data_byte_reg;
  logic                       rsp_error_reg;

  assign cmd_in = '{rw: cmd_rw, dev_addr: cmd_dev_addr, reg_addr: cmd_reg_addr,
                    addr_bytes: cmd_addr_bytes, data_bytes: cmd_data_bytes, wdata: cmd_wdata};
  assign cmd_head = i2c_cmd_t'(head_bits);

  i2c_cmd_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(I2C_CMD_WIDTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid && cmd_ready),
    .push_data (cmd_in),
    .pop       (issue_load),
    .head      (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (cmd_level)
  );

  assign cmd_ready = !fifo_full;

`ifdef I2C_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] timeout_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_cnt_reg <= '0;
    end else if (state_reg == ST_ISSUE) begin
      timeout_cnt_reg <= '0;
    end else if (state_reg == ST_WAIT_BUSY || state_reg == ST_WAIT_DONE) begin
      timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = (state_reg == ST_WAIT_BUSY || state_reg == ST_WAIT_DONE) &&
                       (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // The head is popped on the edge into ISSUE so the controller sees valid
  // fields in the same cycle as the request pulse.
  always_comb begin
    state_next  = state_reg;
    issue_load  = 1'b0;
    capture     = 1'b0;
    capture_err = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && !busy) begin
          issue_load = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        if (access_complete || invalid_access || timeout_hit) begin
          capture     = 1'b1;
          capture_err = invalid_access || (timeout_hit && !access_complete);
          state_next  = ST_RESPOND;
        end else if (state_reg == ST_WAIT_BUSY && busy) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_reg           <= 1'b0;
      dev_id_reg       <= '0;
      address_reg      <= '0;
      address_byte_reg <= '0;
      data_byte_reg    <= '0;
      write_data_reg   <= '0;
      rsp_rdata_reg    <= '0;
      rsp_error_reg    <= 1'b0;
    end else begin
      if (issue_load) begin
        rw_reg           <= cmd_head.rw;
        dev_id_reg       <= {cmd_head.dev_addr, cmd_head.rw};
        address_reg      <= cmd_head.reg_addr;
        address_byte_reg <= cmd_head.addr_bytes;
        data_byte_reg    <= cmd_head.data_bytes;
        write_data_reg   <= cmd_head.wdata;
      end
      if (capture) begin
        rsp_rdata_reg <= (rw_reg && !capture_err) ? read_data : '0;
        rsp_error_reg <= capture_err;
      end
    end
  end

  assign access_request = (state_reg == ST_ISSUE);
  assign rsp_valid      = (state_reg == ST_RESPOND);
  assign rsp_rdata      = rsp_rdata_reg;
  assign rsp_error      = rsp_error_reg;
  assign dev_id         = dev_id_reg;
  assign address        = address_reg;
  assign address_byte   = address_byte_reg;
  assign data_byte      = data_byte_reg;
  assign write_data     = write_data_reg;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer with a behavioural I2C controller model.
module tb_i2c_cmd_sequencer;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [6:0]  cmd_dev_addr;
  logic [31:0] cmd_reg_addr, cmd_wdata;
  logic [1:0]  cmd_addr_bytes, cmd_data_bytes;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        access_request;
  logic [7:0]  dev_id;
  logic [31:0] address, write_data, read_data;
  logic [1:0]  address_byte, data_byte;
  logic        access_complete, invalid_access, busy;
  logic [2:0]  cmd_level;
  logic        model_busy, hold_busy;

  assign busy = model_busy || hold_busy;

  i2c_cmd_sequencer #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_addr_bytes(cmd_addr_bytes), .cmd_data_bytes(cmd_data_bytes), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .access_request(access_request), .dev_id(dev_id), .address(address),
    .address_byte(address_byte), .data_byte(data_byte), .write_data(write_data),
    .read_data(read_data), .access_complete(access_complete), .invalid_access(invalid_access),
    .busy(busy), .cmd_level(cmd_level)
  );

  // Controller behaviour per command: 0 normal, 1 invalid_access, 2 silent,
  // 3 complete without busy, 4 complete and invalid together.
  typedef struct {
    logic [7:0]  dev_id;
    logic [31:0] addr;
    logic [1:0]  ab;
    logic [1:0]  db;
    logic [31:0] wdata;
    logic        rw;
    int          mode;
  } req_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hs_cycle = -1;
  int   req_cyc = 0;
  int   rsp_cyc = 0;
  int   req_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ctrl_rdata(input logic [31:0] a);
    if (a == 32'h20) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  initial begin : ctrl_model
    req_t r;
    forever begin
      @(negedge clk);
      if (access_request === 1'b1) begin
        req_cnt++;
        req_cyc = cyc;
        checks++;
        if (exp_req_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_request: got dev_id %h, required no request", dev_id);
          r.mode = 0;
        end else begin
          r = exp_req_q.pop_front();
          checks++;
          if (dev_id !== r.dev_id || address !== r.addr || address_byte !== r.ab ||
              data_byte !== r.db || (!r.rw && write_data !== r.wdata)) begin
            fails++;
            $display("FAIL request_fields: got %h/%h/%0d/%0d/%h required %h/%h/%0d/%0d/%h",
                     dev_id, address, address_byte, data_byte, write_data,
                     r.dev_id, r.addr, r.ab, r.db, r.wdata);
          end
        end
        checks++;
        if (cyc < hs_cycle + 1) begin
          fails++;
          $display("FAIL issue_gap: got request in cycle %0d, handshake cycle %0d", cyc, hs_cycle);
        end
        @(negedge clk);
        checks++;
        if (access_request !== 1'b0) begin
          fails++;
          $display("FAIL request_pulse: got %b required 0", access_request);
        end
        if (r.mode == 2) begin
          model_busy = 1'b1;
        end else begin
          if (r.mode != 3) begin
            model_busy = 1'b1;
            repeat (2) @(negedge clk);
          end
          read_data       = ctrl_rdata(address);
          access_complete = (r.mode != 1);
          invalid_access  = (r.mode == 1 || r.mode == 4);
          @(negedge clk);
          checks++;
          if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL complete_latency: got rsp_valid %b required 1", rsp_valid);
          end
          access_complete = 1'b0;
          invalid_access  = 1'b0;
          model_busy      = 1'b0;
          read_data       = 32'h0;
        end
      end
    end
  end

  task automatic push_cmd(input logic rw, input logic [6:0] dev, input logic [31:0] ra,
                          input logic [1:0] ab, input logic [1:0] db, input logic [31:0] wd,
                          input int mode);
    int   n = 0;
    req_t q;
    rsp_t s;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_addr = dev; cmd_reg_addr = ra;
    cmd_addr_bytes = ab; cmd_data_bytes = db; cmd_wdata = wd;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL push_ready: got cmd_ready %b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    q.dev_id = {dev, rw}; q.addr = ra; q.ab = ab; q.db = db; q.wdata = wd; q.rw = rw; q.mode = mode;
    s.err   = (mode == 1 || mode == 2 || mode == 4);
    s.rdata = (rw && (mode == 0 || mode == 3)) ? ctrl_rdata(ra) : 32'h0;
    exp_req_q.push_back(q);
    exp_rsp_q.push_back(s);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold);
    int   n = 0;
    rsp_t e;
    while (rsp_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL rsp_timeout: got rsp_valid %b required 1 within 2000 cycles", rsp_valid);
      return;
    end
    rsp_cyc = cyc;
    if (exp_rsp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_rsp: got rdata %h error %b, required none", rsp_rdata, rsp_error);
      return;
    end
    e = exp_rsp_q.pop_front();
    if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
      fails++;
      $display("FAIL rsp_data: got rdata %h error %b required rdata %h error %b",
               rsp_rdata, rsp_error, e.rdata, e.err);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_error !== e.err) begin
        fails++;
        $display("FAIL rsp_stable: got valid %b rdata %h error %b required 1 %h %b",
                 rsp_valid, rsp_rdata, rsp_error, e.rdata, e.err);
      end
    end
    rsp_ready = 1'b1;
    hs_cycle  = cyc;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rsp_drop: got rsp_valid %b required 0 after handshake", rsp_valid);
    end
    $display("rsp: rdata=%h error=%b expected rdata=%h error=%b cycle=%0d",
             rsp_rdata, rsp_error, e.rdata, e.err, hs_cycle);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (access_request !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_rsp: got req %b valid %b rdata %h err %b required all 0",
               access_request, rsp_valid, rsp_rdata, rsp_error);
    end
    checks++;
    if (dev_id !== 8'h0 || address !== 32'h0 || address_byte !== 2'h0 ||
        data_byte !== 2'h0 || write_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_ctrl: got %h %h %h %h %h required all 0",
               dev_id, address, address_byte, data_byte, write_data);
    end
    checks++;
    if (cmd_level !== 3'd0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_fifo: got level %0d ready %b required 0 1", cmd_level, cmd_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (access_request !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL post_reset: got req %b ready %b required 0 1", access_request, cmd_ready);
    end
  endtask

  task automatic test_write();
    int start_cnt = req_cnt;
    push_cmd(1'b0, 7'h50, 32'h10, 2'd1, 2'd1, 32'hA5, 0);
    wait_rsp(0);
    checks++;
    if (req_cnt - start_cnt !== 1) begin
      fails++;
      $display("FAIL write_req_count: got %0d requests required 1", req_cnt - start_cnt);
    end
  endtask

  task automatic test_read();
    push_cmd(1'b1, 7'h50, 32'h20, 2'd1, 2'd3, 32'h0, 0);
    wait_rsp(0);
  endtask

  task automatic test_fifo_full();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      push_cmd(1'(i % 2), 7'h10 + 7'(i), 32'h100 + 32'(i * 4), 2'(i), 2'(3 - i), 32'h55AA0000 + 32'(i), 0);
    checks++;
    if (cmd_level !== 3'd4 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL fifo_full: got level %0d ready %b required 4 0", cmd_level, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_dev_addr = 7'h7F;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (cmd_level !== 3'd4 || cmd_ready !== 1'b0 || access_request !== 1'b0) begin
        fails++;
        $display("FAIL fifo_overflow: got level %0d ready %b req %b required 4 0 0",
                 cmd_level, cmd_ready, access_request);
      end
    end
    cmd_valid = 1'b0;
    hold_busy = 1'b0;
    for (int i = 0; i < 4; i++) wait_rsp(0);
  endtask

  task automatic test_invalid_hold();
    push_cmd(1'b1, 7'h22, 32'h30, 2'd2, 2'd2, 32'h0, 1);
    wait_rsp(10);
  endtask

  task automatic test_back_to_back();
    push_cmd(1'b0, 7'h41, 32'h44, 2'd1, 2'd2, 32'h12345678, 0);
    push_cmd(1'b1, 7'h42, 32'h20, 2'd1, 2'd3, 32'h0, 3);
    push_cmd(1'b1, 7'h43, 32'h48, 2'd2, 2'd1, 32'h0, 4);
    repeat (3) wait_rsp(0);
    checks++;
    if (exp_req_q.size() != 0 || cmd_level !== 3'd0) begin
      fails++;
      $display("FAIL drain: got %0d pending level %0d required 0 0", exp_req_q.size(), cmd_level);
    end
  endtask

`ifdef I2C_TIMEOUT_EN
  task automatic test_timeout();
    push_cmd(1'b1, 7'h33, 32'h60, 2'd1, 2'd3, 32'h0, 2);
    wait_rsp(0);
    checks++;
    if (rsp_cyc - req_cyc < 100 || rsp_cyc - req_cyc > 102) begin
      fails++;
      $display("FAIL timeout_latency: got %0d cycles required 100..102", rsp_cyc - req_cyc);
    end
    model_busy = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_reset_in_flight();
    push_cmd(1'b1, 7'h66, 32'h70, 2'd1, 2'd3, 32'h0, 2);
    repeat (5) @(negedge clk);
    push_cmd(1'b0, 7'h67, 32'h74, 2'd1, 2'd1, 32'h9, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_level !== 3'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got level %0d busy %b required 1 1", cmd_level, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (access_request !== 1'b0 || rsp_valid !== 1'b0 || cmd_level !== 3'd0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: got req %b valid %b level %0d ready %b required 0 0 0 1",
               access_request, rsp_valid, cmd_level, cmd_ready);
    end
    exp_req_q.delete();
    exp_rsp_q.delete();
    model_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (access_request !== 1'b0 || rsp_valid !== 1'b0 || cmd_level !== 3'd0) begin
      fails++;
      $display("FAIL after_reset: got req %b valid %b level %0d required 0 0 0",
               access_request, rsp_valid, cmd_level);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev_addr = 7'h0; cmd_reg_addr = 32'h0;
    cmd_addr_bytes = 2'd0; cmd_data_bytes = 2'd0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
    read_data = 32'h0; access_complete = 1'b0; invalid_access = 1'b0;
    model_busy = 1'b0; hold_busy = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_invalid_hold();
    test_back_to_back();
`ifdef I2C_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
